// File: rtl/dl_ram_rd_control.sv
// Downlink RAM read controller.
// Drains one full RAM buffer (ping-pong pair RAM0/RAM1) per frame into a
// 2-entry skid buffer, hands the bytes to a ready/valid serializer with frame
// markers, then returns the buffer to the write controller with a one-cycle
// "consumed" pulse.
module dl_ram_rd_control #(
   parameter int         FRAME_LEN = 38,
   parameter logic [6:0] RAM0_BASE = 7'd0,
   parameter logic [6:0] RAM1_BASE = 7'd64
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [1:0] DlRAM_wr_state,
   input  logic [7:0] rdDlRAMData,
   output logic [6:0] rdDlRAMAddr,
   output logic       rdDlRAMEn,
   output logic [1:0] DlRAM_rd_state,
   output logic [7:0] outData,
   output logic       outValid,
   input  logic       outReady,
   output logic       frameStart,
   output logic       frameEnd,
   output logic       rdBusy
);

   // Controller states
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_CLEAR = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   // Index of the last byte of a frame, in the 7-bit index domain
   localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;

   // Selected RAM for the current frame (0 = RAM0, 1 = RAM1)
   logic       sel;
   // RAM whose buffer was most recently returned; resets to RAM1 so RAM0 wins first
   logic       last_served;
   logic       pick;

   // Read-side index (next address to strobe) and output-side index (next byte to hand over)
   logic [6:0] rd_idx;
   logic [6:0] out_idx;

   // A strobe was issued last cycle, so rdDlRAMData carries a byte this cycle
   logic       in_flight;

   // Skid storage: head in skid0, second entry in skid1
   logic [1:0] skid_cnt;
   logic [7:0] skid0;
   logic [7:0] skid1;

   logic       issue;
   logic       take;
   logic       last_byte;
   logic [6:0] base;

   // Arbitration and datapath helpers.
   // The byte returning from the RAM counts as already in the skid buffer in
   // the cycle it arrives, so the head is the stored entry if there is one,
   // otherwise the byte on rdDlRAMData.  A strobe is only allowed while fewer
   // than two bytes are committed (stored plus in flight), which bounds the
   // storage to two entries whatever the downstream does.
   always_comb begin
      pick = 1'b0;
      if (DlRAM_wr_state == 2'b11) begin
         pick = ~last_served;
      end else begin
         pick = DlRAM_wr_state[1];
      end

      base      = sel ? RAM1_BASE : RAM0_BASE;
      issue     = (state == S_READ) && ((skid_cnt + {1'b0, in_flight}) < 2'd2);
      outValid  = (skid_cnt != 2'd0) || in_flight;
      take      = outValid && outReady;
      last_byte = (out_idx == LAST_IDX);

      outData = 8'h00;
      if (skid_cnt != 2'd0) begin
         outData = skid0;
      end else if (in_flight) begin
         outData = rdDlRAMData;
      end

      rdDlRAMEn   = issue;
      rdDlRAMAddr = issue ? (base + rd_idx) : 7'd0;

      frameStart = outValid && (out_idx == 7'd0);
      frameEnd   = outValid && last_byte;

      DlRAM_rd_state = 2'b00;
      if (state == S_CLEAR) begin
         DlRAM_rd_state = sel ? 2'b10 : 2'b01;
      end

      rdBusy = (state != S_IDLE);
   end

   // Next-state logic; flag changes are only looked at in S_IDLE, so a
   // writer that drops its flag mid-frame or clears it late has no effect.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (DlRAM_wr_state != 2'b00) begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (issue && (rd_idx == LAST_IDX)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (take && last_byte) begin
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: state_nxt = S_HOLD;
         S_HOLD:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the chosen RAM at frame start and remember it once its buffer is returned
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sel         <= 1'b0;
         last_served <= 1'b1;
      end else begin
         if ((state == S_IDLE) && (DlRAM_wr_state != 2'b00)) begin
            sel <= pick;
         end
         if (state == S_CLEAR) begin
            last_served <= sel;
         end
      end
   end

   // Read index: restarts at 0 every frame, advances once per strobe
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rd_idx <= 7'd0;
      end else if (state == S_IDLE) begin
         rd_idx <= 7'd0;
      end else if (issue) begin
         rd_idx <= rd_idx + 7'd1;
      end
   end

   // Track whether a RAM byte is due this cycle
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
      end
   end

   // Output index: position within the frame of the byte currently presented
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         out_idx <= 7'd0;
      end else if (state == S_IDLE) begin
         out_idx <= 7'd0;
      end else if (take) begin
         out_idx <= last_byte ? 7'd0 : (out_idx + 7'd1);
      end
   end

   // Skid buffer: store the arriving byte unless it is handed straight through,
   // and shift the second entry forward when the head is accepted
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         skid_cnt <= 2'd0;
         skid0    <= 8'h00;
         skid1    <= 8'h00;
      end else begin
         case (skid_cnt)
            2'd0: begin
               if (in_flight && !take) begin
                  skid0    <= rdDlRAMData;
                  skid_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (take && in_flight) begin
                  skid0 <= rdDlRAMData;
               end else if (take) begin
                  skid_cnt <= 2'd0;
               end else if (in_flight) begin
                  skid1    <= rdDlRAMData;
                  skid_cnt <= 2'd2;
               end
            end
            2'd2: begin
               if (take && in_flight) begin
                  skid0 <= skid1;
                  skid1 <= rdDlRAMData;
               end else if (take) begin
                  skid0    <= skid1;
                  skid_cnt <= 2'd1;
               end
            end
            default: begin
               skid_cnt <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dl_ram_rd_control.sv
// Testbench for dl_ram_rd_control: RAM and write-controller models, a
// frame-level reference model of the expected byte stream, and a second
// instance with single-byte frames.
module tb_dl_ram_rd_control;

   localparam int FL = 38;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nRst;
   logic [1:0] wr_flags    = 2'b00;
   logic [1:0] pending_clr = 2'b00;
   logic [1:0] set_req     = 2'b00;
   logic [7:0] rd_data;
   logic [6:0] rd_addr;
   logic       rd_en;
   logic [1:0] rd_state;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_start;
   logic       frame_end;
   logic       rd_busy;

   logic [1:0] wr_flags1 = 2'b00;
   logic [1:0] set1      = 2'b00;
   logic [7:0] rd_data1;
   logic [6:0] rd_addr1;
   logic       rd_en1;
   logic [1:0] rd_state1;
   logic [7:0] out_data1;
   logic       out_valid1;
   logic       frame_start1;
   logic       frame_end1;
   logic       rd_busy1;

   logic [7:0] mem [128];
   int         rdy_pct;

   int checks = 0;
   int errors = 0;

   dl_ram_rd_control #(.FRAME_LEN(FL)) u_dut (
      .clk(clk), .nRst(nRst), .DlRAM_wr_state(wr_flags), .rdDlRAMData(rd_data),
      .rdDlRAMAddr(rd_addr), .rdDlRAMEn(rd_en), .DlRAM_rd_state(rd_state),
      .outData(out_data), .outValid(out_valid), .outReady(out_ready),
      .frameStart(frame_start), .frameEnd(frame_end), .rdBusy(rd_busy)
   );

   dl_ram_rd_control #(.FRAME_LEN(1)) u_dut1 (
      .clk(clk), .nRst(nRst), .DlRAM_wr_state(wr_flags1), .rdDlRAMData(rd_data1),
      .rdDlRAMAddr(rd_addr1), .rdDlRAMEn(rd_en1), .DlRAM_rd_state(rd_state1),
      .outData(out_data1), .outValid(out_valid1), .outReady(1'b1),
      .frameStart(frame_start1), .frameEnd(frame_end1), .rdBusy(rd_busy1)
   );

   // RAM (one-cycle read latency, garbage when not read) and a writer that
   // clears its full flag one cycle late and refills any flag in set_req
   always @(posedge clk) begin
      pending_clr <= rd_state;
      wr_flags    <= (wr_flags | set_req) & ~pending_clr;
      rd_data     <= rd_en ? mem[rd_addr] : 8'($urandom);
      wr_flags1   <= (wr_flags1 | set1) & ~rd_state1;
      rd_data1    <= rd_en1 ? mem[rd_addr1] : 8'($urandom);
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] baseOf(input bit ram);
      return ram ? 7'd64 : 7'd0;
   endfunction

   // Reference model state
   bit         busy_prev = 1'b0;
   bit         in_frame  = 1'b0;
   bit         pulse_due = 1'b0;
   bit         lat_chk   = 1'b0;
   bit         stalled   = 1'b0;
   bit         last_ram  = 1'b1;
   bit         cur_ram   = 1'b0;
   logic [1:0] prev_flags = 2'b00;
   int         strobes   = 0;
   int         accepts   = 0;
   int         pulse_cnt = 0;
   logic [1:0] last_pulse = 2'b00;
   logic [7:0] held_data;
   logic       held_fs;
   logic       held_fe;
   logic [7:0] exp_q [$];

   // Frame-level model: choose the RAM from the flags seen while idle, expect
   // its FRAME_LEN bytes in address order, one returned-buffer pulse after the
   // last byte, and never more than two bytes strobed but not yet accepted
   always @(negedge clk) begin
      if (!nRst) begin
         busy_prev = 1'b0;
         in_frame  = 1'b0;
         pulse_due = 1'b0;
         lat_chk   = 1'b0;
         stalled   = 1'b0;
         strobes   = 0;
         accepts   = 0;
         last_ram  = 1'b1;
         exp_q.delete();
      end else begin
         if (pulse_due || (rd_state != 2'b00)) begin
            checkOutput("rd_state", 32'(rd_state), pulse_due ? (cur_ram ? 32'd2 : 32'd1) : 32'd0);
            if (rd_state != 2'b00) begin
               pulse_cnt++;
               last_pulse = rd_state;
            end
            if (pulse_due) begin
               last_ram  = cur_ram;
               in_frame  = 1'b0;
               pulse_due = 1'b0;
            end
         end
         if (lat_chk) begin
            checkOutput("first_valid_latency", 32'(out_valid), 32'd1);
            lat_chk = 1'b0;
         end
         if (rd_busy && !busy_prev) begin
            checkOutput("start_needs_flag", 32'(prev_flags != 2'b00), 32'd1);
            cur_ram = (prev_flags == 2'b11) ? ~last_ram : prev_flags[1];
            exp_q.delete();
            for (int i = 0; i < FL; i++) exp_q.push_back(mem[baseOf(cur_ram) + 7'(i)]);
            strobes  = 0;
            accepts  = 0;
            in_frame = 1'b1;
            lat_chk  = 1'b1;
         end
         if (rd_en) begin
            checkOutput("strobe_in_frame", 32'(in_frame && (strobes < FL)), 32'd1);
            checkOutput("strobe_room", 32'((strobes - accepts) < 2), 32'd1);
            checkOutput("rd_addr", 32'(rd_addr), 32'(baseOf(cur_ram) + 7'(strobes)));
            strobes++;
         end
         if (stalled) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(out_data), 32'(held_data));
            checkOutput("stall_start", 32'(frame_start), 32'(held_fs));
            checkOutput("stall_end", 32'(frame_end), 32'(held_fe));
         end
         stalled   = out_valid && !out_ready;
         held_data = out_data;
         held_fs   = frame_start;
         held_fe   = frame_end;
         if (out_valid && out_ready) begin
            checkOutput("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
               checkOutput("frame_start", 32'(frame_start), 32'(accepts == 0));
               checkOutput("frame_end", 32'(frame_end), 32'(accepts == FL - 1));
               accepts++;
               if (accepts == FL) pulse_due = 1'b1;
            end
         end
      end
      busy_prev  = rd_busy;
      prev_flags = wr_flags;
   end

   task automatic stepCycle();
      @(posedge clk);
      #2;
      out_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic applyStimulus(input logic [1:0] req, input int pct);
      set_req = req;
      rdy_pct = pct;
   endtask

   task automatic waitPulses(input int target, input int budget);
      int n = 0;
      while ((pulse_cnt < target) && (n < budget)) begin
         stepCycle();
         n++;
      end
      checkOutput("pulse_count", 32'(pulse_cnt), 32'(target));
   endtask

   task automatic waitQuiet(input int budget);
      int quiet = 0;
      int n = 0;
      while ((quiet < 6) && (n < budget)) begin
         stepCycle();
         n++;
         quiet = rd_busy ? 0 : quiet + 1;
      end
      checkOutput("quiet", 32'(quiet >= 6), 32'd1);
   endtask

   task automatic resetPulse();
      @(posedge clk);
      #2 nRst = 1'b0;
      repeat (2) @(posedge clk);
      #2 nRst = 1'b1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},  32'(rd_busy), 32'd0);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_data"},  32'(out_data), 32'd0);
      checkOutput({tag, "_en"},    32'(rd_en), 32'd0);
      checkOutput({tag, "_addr"},  32'(rd_addr), 32'd0);
      checkOutput({tag, "_rdst"},  32'(rd_state), 32'd0);
      checkOutput({tag, "_fs"},    32'(frame_start), 32'd0);
      checkOutput({tag, "_fe"},    32'(frame_end), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int saved;
      int n;
      bit busy_seen;
      nRst      = 1'b0;
      out_ready = 1'b0;
      rdy_pct   = 100;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      for (int i = 64; i < 128; i++) mem[i] = 8'($urandom);
      #3;
      checkAllZero("reset");
      repeat (2) @(posedge clk);
      #2 nRst = 1'b1;

      // RAM0 only, downstream always ready, writer clears its flag late
      applyStimulus(2'b01, 100);
      waitPulses(1, 200);
      checkOutput("pulse_ram0", 32'(last_pulse), 32'd1);
      applyStimulus(2'b00, 100);
      busy_seen = 1'b0;
      repeat (12) begin
         stepCycle();
         busy_seen |= rd_busy;
      end
      checkOutput("no_reread", 32'(busy_seen), 32'd0);
      checkOutput("pulse_total", 32'(pulse_cnt), 32'd1);

      // Both full after reset: RAM0 then RAM1
      resetPulse();
      applyStimulus(2'b11, 100);
      waitPulses(2, 200);
      checkOutput("order_first", 32'(last_pulse), 32'd1);
      waitPulses(3, 200);
      checkOutput("order_second", 32'(last_pulse), 32'd2);

      // Random backpressure across several frames
      applyStimulus(2'b11, 50);
      waitPulses(7, 3000);
      applyStimulus(2'b00, 100);
      waitQuiet(600);

      // Reset in the middle of a RAM1 frame
      applyStimulus(2'b10, 50);
      n = 0;
      while (!(in_frame && cur_ram && (accepts >= 20)) && (n < 800)) begin
         stepCycle();
         n++;
      end
      checkOutput("reached_byte20", 32'(in_frame && cur_ram && (accepts >= 20)), 32'd1);
      saved = pulse_cnt;
      nRst  = 1'b0;
      #1;
      checkAllZero("async_rst");
      repeat (2) @(posedge clk);
      #2 nRst = 1'b1;
      checkOutput("no_pulse_in_reset", 32'(pulse_cnt), 32'(saved));
      waitPulses(saved + 1, 800);
      checkOutput("reread_ram1", 32'(last_pulse), 32'd2);
      applyStimulus(2'b00, 100);
      waitQuiet(600);

      // Single-byte frames on the second instance
      stepCycle();
      set1 = 2'b01;
      stepCycle();
      set1 = 2'b00;
      n = 0;
      while (!out_valid1 && (n < 10)) begin
         stepCycle();
         n++;
      end
      checkOutput("f1_latency", 32'(n), 32'd2);
      checkOutput("f1_valid", 32'(out_valid1), 32'd1);
      checkOutput("f1_data", 32'(out_data1), 32'(mem[0]));
      checkOutput("f1_start", 32'(frame_start1), 32'd1);
      checkOutput("f1_end", 32'(frame_end1), 32'd1);
      stepCycle();
      checkOutput("f1_valid_after", 32'(out_valid1), 32'd0);
      checkOutput("f1_pulse", 32'(rd_state1), 32'd1);
      stepCycle();
      checkOutput("f1_hold_rdst", 32'(rd_state1), 32'd0);
      checkOutput("f1_hold_busy", 32'(rd_busy1), 32'd1);
      stepCycle();
      checkOutput("f1_idle", 32'(rd_busy1), 32'd0);
      stepCycle();
      checkOutput("f1_stay_idle", 32'(rd_busy1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dl_ram_rd_control.md
DL_RAM_RD_CONTROL -- requirements
Module: dl_ram_rd_control

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 38, bytes read per frame (1..64).
REQ-002 SHALL have parameter RAM0_BASE, default 7'd0, first byte address of RAM0.
REQ-003 SHALL have parameter RAM1_BASE, default 7'd64, first byte address of RAM1.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port nRst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port DlRAM_wr_state  in  2  per-RAM full flags from the write controller (bit0=RAM0, bit1=RAM1).
REQ-007 SHALL have port rdDlRAMData  in  8  RAM read data, valid exactly one cycle after rdDlRAMEn.
REQ-008 SHALL have port rdDlRAMAddr  out  7  RAM read address.
REQ-009 SHALL have port rdDlRAMEn  out  1  RAM read strobe.
REQ-010 SHALL have port DlRAM_rd_state  out  2  one-cycle "buffer consumed" pulse per RAM, clears the matching full flag.
REQ-011 SHALL have port outData  out  8  byte to downstream serializer.
REQ-012 SHALL have port outValid  out  1  outData valid.
REQ-013 SHALL have port outReady  in  1  downstream accepts; transfer when outValid&&outReady.
REQ-014 SHALL have port frameStart  out  1  high with first byte of a frame while outValid.
REQ-015 SHALL have port frameEnd  out  1  high with last byte of a frame while outValid.
REQ-016 SHALL have port rdBusy  out  1  high in every state except S_IDLE.

Function
REQ-017 SHALL implement states S_IDLE, S_READ, S_DRAIN, S_CLEAR, S_HOLD.
REQ-018 S_IDLE SHALL select a RAM when any DlRAM_wr_state bit is 1 and go to S_READ next cycle.
REQ-019 Selection SHALL alternate: if both full, pick the RAM not served last; after reset RAM0 has priority.
REQ-020 S_READ SHALL issue rdDlRAMEn with rdDlRAMAddr = base + index, index 0..FRAME_LEN-1, incrementing per strobe.
REQ-021 Read issue SHALL occur only when (skid occupancy + reads in flight) < 2; skid buffer is 2 entries deep.
REQ-022 Returned rdDlRAMData SHALL enter the skid buffer the cycle after its strobe; outData/outValid SHALL present the buffer head.
REQ-023 Bytes SHALL emerge in address order with no loss or duplication under any outReady pattern.
REQ-024 outData/outValid/frameStart/frameEnd SHALL remain stable while outValid&&!outReady.
REQ-025 After the FRAME_LEN-th strobe the FSM SHALL enter S_DRAIN and issue no further reads.
REQ-026 S_DRAIN SHALL exit to S_CLEAR in the cycle after the frameEnd byte is accepted.
REQ-027 S_CLEAR SHALL last one cycle with DlRAM_rd_state bit of the selected RAM = 1, other bit 0.
REQ-028 S_HOLD SHALL last one cycle, ignoring DlRAM_wr_state (stale flag), then go to S_IDLE.
REQ-029 Minimum frame-to-frame gap: S_IDLE re-evaluation no sooner than 2 cycles after the last accepted byte.
REQ-030 Full-flag deassertion during S_READ/S_DRAIN SHALL be ignored; frame completes.
REQ-031 Index counter SHALL be 7 bits; address = base + index, no wrap beyond FRAME_LEN-1.
REQ-032 With outReady held 1, first outValid SHALL occur 2 cycles after S_IDLE sees a full flag, then one byte per cycle.

Reset
REQ-033 On nRst=0 all outputs SHALL be 0 immediately, state S_IDLE, skid empty, in-flight reads discarded, priority RAM0.
REQ-034 Reset mid-frame SHALL not pulse DlRAM_rd_state; the buffer stays full and is re-read from index 0 after reset.

Verification
REQ-035 DlRAM_wr_state=01, RAM0[i]=i, outReady=1 -> 38 bytes 0x00..0x25 on consecutive cycles, frameStart on 0x00, frameEnd on 0x25, DlRAM_rd_state=01 for one cycle.
REQ-036 DlRAM_wr_state=11 held after reset -> RAM0 frame, then RAM1 frame (addresses 64..101), rd_state pulses 01 then 10.
REQ-037 outReady toggled randomly 50% during frame -> exactly 38 bytes, in order, outputs stable while stalled, rdDlRAMEn never with 2 entries committed.
REQ-038 Writer clears flag one cycle after rd_state pulse -> no second read of same RAM (S_HOLD covers stale flag).
REQ-039 nRst asserted at byte 20 of RAM1 frame -> outputs 0 asynchronously, no rd_state pulse, after release RAM1 re-read from address 64 with frameStart.
REQ-040 FRAME_LEN=1 -> single byte with frameStart and frameEnd both high, then rd_state pulse.
